sqrt_gen: RTL

SQRT_GEN -- requirements
Module: sqrt_gen

---
 rtl/sqrt_pkg.sv | 7 +
 rtl/sqrt_step.sv | 24 ++
 rtl/sqrt_gen.sv | 74 +++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: FSM state encoding and root-width helper for the square-root generator.
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, WORK, DONE} state_t;
  function automatic int root_w(input int w);
    return w / 2 + 1;
  endfunction
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one digit-by-digit iteration resolving a single root bit.
module sqrt_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH/2-1:0] rem_i,
  input  logic [WIDTH/2-1:0] root_i,
  input  logic [1:0]         pair_i,
  output logic [WIDTH/2:0]   rem_o,
  output logic [WIDTH/2-1:0] root_o
);
  localparam int H = WIDTH / 2;
  logic [H+1:0] cur, trial;
  logic [H:0] diff;
  logic ge;
  // the true difference never exceeds H+1 bits when the trial fits
  always_comb begin
    cur    = {rem_i, pair_i};
    trial  = {root_i, 2'b01};
    ge     = cur >= trial;
    diff   = cur[H:0] - trial[H:0];
    rem_o  = ge ? diff : cur[H:0];
    root_o = {root_i[H-2:0], ge};
  end
endmodule

// File: rtl/sqrt_gen.sv
// sqrt_gen: sequential integer square root, one root bit per cycle, optional rounding.
module sqrt_gen
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [WIDTH-1:0]           a_bi,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [root_w(WIDTH)-1:0]   y_bo,
  output logic [root_w(WIDTH)-1:0]   rem_bo
);
  localparam int H  = WIDTH / 2;
  localparam int RW = root_w(WIDTH);
  localparam int CW = $clog2(H + 1);
  if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
    $error("sqrt_gen: WIDTH must be even and at least 4");
  end
  state_t state;
  logic [WIDTH-1:0] a_q;
  logic [H:0] rem_q, rem_n;
  logic [H-1:0] root_q, root_n;
  logic [CW-1:0] cnt;
  logic rnd;
  assign rnd = ROUND != 0 && rem_q > {1'b0, root_q};
  sqrt_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q[H-1:0]),
    .root_i(root_q),
    .pair_i(a_q[WIDTH-1 -: 2]),
    .rem_o (rem_n),
    .root_o(root_n)
  );
  // the cycle after the last iteration (cnt==0) commits the result with rounding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      y_bo   <= '0;
      rem_bo <= '0;
    end else if (state == WORK) begin
      if (cnt != '0) begin
        a_q    <= a_q << 2;
        rem_q  <= rem_n;
        root_q <= root_n;
        cnt    <= cnt - 1'b1;
        busy_o <= cnt != CW'(1);
      end else begin
        state  <= DONE;
        done_o <= 1'b1;
        y_bo   <= {1'b0, root_q} + {{(RW-1){1'b0}}, rnd};
        rem_bo <= rem_q;
      end
    end else begin
      done_o <= 1'b0;
      state  <= start_i ? WORK : IDLE;
      busy_o <= start_i;
      if (start_i) begin
        a_q    <= a_bi;
        rem_q  <= '0;
        root_q <= '0;
        cnt    <= CW'(H);
      end
    end
  end
endmodule
